// File: rtl/gemm_sched_pkg.sv
// Shared types and helpers for the GeMM job scheduler front end.
// Holds the FSM state encoding, record field width helpers and the size legality check.
package gemm_sched_pkg;

  typedef enum logic [1:0] {
    SchedIdle,
    SchedLaunch,
    SchedRun,
    SchedComplete
  } sched_state_e;

  localparam int unsigned DefAddrWidth = 8;
  localparam int unsigned DefIdWidth   = 4;

  function automatic int unsigned req_idx_width(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // A size triple is legal only when every dimension is a nonzero multiple of its tile.
  function automatic logic is_legal_size(input logic [31:0] m, input logic [31:0] k,
                                         input logic [31:0] n, input int unsigned tile_m,
                                         input int unsigned tile_k, input int unsigned tile_n);
    return (m != 0) && (k != 0) && (n != 0) &&
           ((m % tile_m) == 0) && ((k % tile_k) == 0) && ((n % tile_n) == 0);
  endfunction

endpackage

// File: rtl/gemm_job_fifo.sv
// Show-ahead synchronous FIFO holding packed job records.
// Depth must be a power of two so the pointers wrap naturally.
module gemm_job_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push,
  input  logic [Width-1:0]       push_data,
  input  logic                   pop,
  output logic [Width-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(Depth):0] count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wptr;
  logic [PtrW-1:0]  rptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CntW'(Depth));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PtrW'(1);
      if (do_pop)  rptr <= rptr + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once count says they were written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/gemm_job_scheduler.sv
// Job front end for the GeMM controller: round-robin intake, job FIFO, and a
// launch/complete FSM that rejects illegal sizes without ever starting them.
module gemm_job_scheduler
  import gemm_sched_pkg::*;
#(
  parameter int unsigned AddrWidth  = DefAddrWidth,
  parameter int unsigned NumReq     = 2,
  parameter int unsigned QueueDepth = 4,
  parameter int unsigned IdWidth    = DefIdWidth,
  parameter int unsigned TileM      = 4,
  parameter int unsigned TileK      = 4,
  parameter int unsigned TileN      = 4
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic [NumReq-1:0]                          req_valid_i,
  output logic [NumReq-1:0]                          req_ready_o,
  input  logic [NumReq-1:0][AddrWidth-1:0]           req_m_size_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]           req_k_size_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]           req_n_size_i,
  input  logic [NumReq-1:0][IdWidth-1:0]             req_id_i,
  output logic                                       start_o,
  output logic [AddrWidth-1:0]                       m_size_o,
  output logic [AddrWidth-1:0]                       k_size_o,
  output logic [AddrWidth-1:0]                       n_size_o,
  input  logic                                       done_i,
  output logic                                       cpl_valid_o,
  input  logic                                       cpl_ready_i,
  output logic [IdWidth-1:0]                         cpl_id_o,
  output logic [((NumReq > 1) ? $clog2(NumReq) : 1)-1:0] cpl_req_o,
  output logic                                       cpl_err_o,
  output logic [$clog2(QueueDepth):0]                queue_count_o,
  output logic                                       idle_o
);

  localparam int unsigned ReqW = req_idx_width(NumReq);

  typedef struct packed {
    logic                 err;
    logic [ReqW-1:0]      req;
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] m;
    logic [AddrWidth-1:0] k;
    logic [AddrWidth-1:0] n;
  } job_t;

  sched_state_e    state;
  logic [ReqW-1:0] rr_ptr;
  logic [ReqW-1:0] gnt_idx;
  logic            gnt_valid;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  job_t            push_rec;
  job_t            head;
  logic [$bits(job_t)-1:0] head_raw;

  // First valid requester at or after the round-robin pointer wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int unsigned off = 0; off < NumReq; off++) begin
      if (!gnt_valid && req_valid_i[(int'(rr_ptr) + off) % NumReq]) begin
        gnt_valid = 1'b1;
        gnt_idx   = ReqW'((int'(rr_ptr) + off) % NumReq);
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (gnt_valid && !full) req_ready_o[gnt_idx] = 1'b1;
  end

  assign push = gnt_valid && !full;
  assign pop  = (state == SchedIdle) && !empty;

  always_comb begin
    push_rec.req = gnt_idx;
    push_rec.id  = req_id_i[gnt_idx];
    push_rec.m   = req_m_size_i[gnt_idx];
    push_rec.k   = req_k_size_i[gnt_idx];
    push_rec.n   = req_n_size_i[gnt_idx];
    push_rec.err = !is_legal_size(32'(req_m_size_i[gnt_idx]), 32'(req_k_size_i[gnt_idx]),
                                  32'(req_n_size_i[gnt_idx]), TileM, TileK, TileN);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr <= '0;
    end else if (push) begin
      rr_ptr <= ReqW'((int'(gnt_idx) + 1) % NumReq);
    end
  end

  gemm_job_fifo #(
    .Width($bits(job_t)),
    .Depth(QueueDepth)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push     (push),
    .push_data(push_rec),
    .pop      (pop),
    .pop_data (head_raw),
    .full     (full),
    .empty    (empty),
    .count    (queue_count_o)
  );

  assign head   = job_t'(head_raw);
  assign idle_o = (state == SchedIdle) && empty;

  // The completion fields and size outputs double as the active-job register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= SchedIdle;
      start_o     <= 1'b0;
      cpl_valid_o <= 1'b0;
      cpl_id_o    <= '0;
      cpl_req_o   <= '0;
      cpl_err_o   <= 1'b0;
      m_size_o    <= '0;
      k_size_o    <= '0;
      n_size_o    <= '0;
    end else begin
      case (state)
        SchedIdle: begin
          if (!empty) begin
            cpl_id_o  <= head.id;
            cpl_req_o <= head.req;
            cpl_err_o <= head.err;
            if (head.err) begin
              m_size_o    <= '0;
              k_size_o    <= '0;
              n_size_o    <= '0;
              cpl_valid_o <= 1'b1;
              state       <= SchedComplete;
            end else begin
              m_size_o <= head.m;
              k_size_o <= head.k;
              n_size_o <= head.n;
              start_o  <= 1'b1;
              state    <= SchedLaunch;
            end
          end
        end
        SchedLaunch: begin
          start_o <= 1'b0;
          state   <= SchedRun;
        end
        SchedRun: begin
          if (done_i) begin
            cpl_valid_o <= 1'b1;
            state       <= SchedComplete;
          end
        end
        SchedComplete: begin
          if (cpl_ready_i) begin
            cpl_valid_o <= 1'b0;
            state       <= SchedIdle;
          end
        end
        default: state <= SchedIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_gemm_job_scheduler.sv
// Directed self-checking bench for gemm_job_scheduler (default parameters).
module tb_gemm_job_scheduler;

  logic            clk;
  logic            rst_n;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0][7:0] req_m;
  logic [1:0][7:0] req_k;
  logic [1:0][7:0] req_n;
  logic [1:0][3:0] req_id;
  logic            start;
  logic [7:0]      m_size;
  logic [7:0]      k_size;
  logic [7:0]      n_size;
  logic            done;
  logic            cpl_valid;
  logic            cpl_ready;
  logic [3:0]      cpl_id;
  logic [0:0]      cpl_req;
  logic            cpl_err;
  logic [2:0]      queue_count;
  logic            idle;

  int n_cmp  = 0;
  int n_fail = 0;

  gemm_job_scheduler dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_m_size_i (req_m),
    .req_k_size_i (req_k),
    .req_n_size_i (req_n),
    .req_id_i     (req_id),
    .start_o      (start),
    .m_size_o     (m_size),
    .k_size_o     (k_size),
    .n_size_o     (n_size),
    .done_i       (done),
    .cpl_valid_o  (cpl_valid),
    .cpl_ready_i  (cpl_ready),
    .cpl_id_o     (cpl_id),
    .cpl_req_o    (cpl_req),
    .cpl_err_o    (cpl_err),
    .queue_count_o(queue_count),
    .idle_o       (idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int r, input logic [7:0] m, input logic [7:0] k,
                               input logic [7:0] n, input logic [3:0] id);
    req_valid[r] = 1'b1;
    req_m[r]     = m;
    req_k[r]     = k;
    req_n[r]     = n;
    req_id[r]    = id;
  endtask

  task automatic doReset();
    rst_n     = 1'b0;
    req_valid = '0;
    done      = 1'b0;
    cpl_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int   sent0, sent1, sent, ncpl, ngnt, run_wait;
    logic [1:0] rdy;
    logic r0, any_cpl, any_start;

    rst_n     = 1'b0;
    req_valid = '0;
    req_m     = '0;
    req_k     = '0;
    req_n     = '0;
    req_id    = '0;
    done      = 1'b0;
    cpl_ready = 1'b1;

    // Reset state
    #12;
    checkOutput("rst_idle", idle, 1);
    checkOutput("rst_start", start, 0);
    checkOutput("rst_cpl_valid", cpl_valid, 0);
    checkOutput("rst_count", queue_count, 0);
    checkOutput("rst_ready", req_ready, 0);
    checkOutput("rst_msize", m_size, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single legal job from requester 0
    applyStimulus(0, 8'd8, 8'd4, 8'd12, 4'd3);
    #1 checkOutput("t1_ready", req_ready, 2'b01);
    tick();
    req_valid = '0;
    checkOutput("t1_count", queue_count, 1);
    checkOutput("t1_no_start_yet", start, 0);
    tick();
    checkOutput("t1_start", start, 1);
    checkOutput("t1_m", m_size, 8);
    checkOutput("t1_k", k_size, 4);
    checkOutput("t1_n", n_size, 12);
    checkOutput("t1_count_popped", queue_count, 0);
    tick();
    checkOutput("t1_start_pulse", start, 0);
    checkOutput("t1_m_run", m_size, 8);
    tick();
    tick();
    checkOutput("t1_k_run", k_size, 4);
    checkOutput("t1_no_cpl_yet", cpl_valid, 0);
    done = 1'b1;
    tick();
    done = 1'b0;
    checkOutput("t1_cpl_valid", cpl_valid, 1);
    checkOutput("t1_cpl_id", cpl_id, 3);
    checkOutput("t1_cpl_req", cpl_req, 0);
    checkOutput("t1_cpl_err", cpl_err, 0);
    checkOutput("t1_n_cpl", n_size, 12);
    tick();
    checkOutput("t1_cpl_drop", cpl_valid, 0);
    checkOutput("t1_idle", idle, 1);

    // Both requesters continuously valid: grants and completions alternate 0,1,0,1
    doReset();
    sent0 = 0; sent1 = 0; ncpl = 0; ngnt = 0; run_wait = 0;
    for (int cyc = 0; cyc < 400 && ncpl < 8; cyc++) begin
      req_valid = {sent1 < 4, sent0 < 4};
      req_id[0] = 4'(sent0);
      req_id[1] = 4'(8 + sent1);
      req_m = {8'd4, 8'd4};
      req_k = {8'd8, 8'd8};
      req_n = {8'd4, 8'd4};
      done = (run_wait == 1);
      if (run_wait > 0) run_wait--;
      #1 rdy = req_ready & req_valid;
      tick();
      if (rdy != 2'b00) begin
        checkOutput("t2_grant", rdy, (ngnt % 2 == 0) ? 2'b01 : 2'b10);
        ngnt++;
        if (rdy[0]) sent0++;
        else sent1++;
      end
      if (start) run_wait = 3;
      if (cpl_valid) begin
        checkOutput("t2_cpl_id", cpl_id, (ncpl % 2 == 1) ? 8 + ncpl / 2 : ncpl / 2);
        checkOutput("t2_cpl_req", cpl_req, ncpl % 2);
        checkOutput("t2_cpl_err", cpl_err, 0);
        ncpl++;
      end
    end
    req_valid = '0;
    done = 1'b0;
    checkOutput("t2_all_completed", ncpl, 8);

    // Illegal sizes complete with err and never launch
    doReset();
    applyStimulus(0, 8'd8, 8'd6, 8'd4, 4'd5);
    tick();
    req_valid = '0;
    checkOutput("t3_count", queue_count, 1);
    tick();
    checkOutput("t3_cpl_valid", cpl_valid, 1);
    checkOutput("t3_cpl_err", cpl_err, 1);
    checkOutput("t3_cpl_id", cpl_id, 5);
    checkOutput("t3_no_start", start, 0);
    checkOutput("t3_m_zero", m_size, 0);
    tick();
    checkOutput("t3_cpl_drop", cpl_valid, 0);
    checkOutput("t3_idle", idle, 1);
    applyStimulus(1, 8'd0, 8'd4, 8'd4, 4'd7);
    tick();
    req_valid = '0;
    tick();
    checkOutput("t3_zero_err", cpl_err, 1);
    checkOutput("t3_zero_id", cpl_id, 7);
    checkOutput("t3_zero_req", cpl_req, 1);
    checkOutput("t3_zero_no_start", start, 0);
    tick();
    applyStimulus(1, 8'd4, 8'd8, 8'd16, 4'd6);
    tick();
    req_valid = '0;
    tick();
    checkOutput("t3_legal_start", start, 1);
    checkOutput("t3_legal_m", m_size, 4);
    checkOutput("t3_legal_k", k_size, 8);
    checkOutput("t3_legal_n", n_size, 16);
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    checkOutput("t3_legal_cpl", cpl_valid, 1);
    checkOutput("t3_legal_id", cpl_id, 6);
    checkOutput("t3_legal_err", cpl_err, 0);
    tick();

    // FIFO fills behind a running job; ready returns after the next pop
    doReset();
    applyStimulus(0, 8'd4, 8'd4, 8'd4, 4'd0);
    sent = 0;
    for (int c = 0; c < 10; c++) begin
      req_id[0] = 4'(sent);
      #1 r0 = req_ready[0];
      tick();
      if (r0) sent++;
    end
    checkOutput("t4_accepted", sent, 5);
    checkOutput("t4_full_count", queue_count, 4);
    checkOutput("t4_full_ready", req_ready, 2'b00);
    done = 1'b1;
    tick();
    done = 1'b0;
    checkOutput("t4_cpl_id", cpl_id, 0);
    checkOutput("t4_still_full", req_ready, 2'b00);
    tick();
    checkOutput("t4_count_hold", queue_count, 4);
    tick();
    checkOutput("t4_count_pop", queue_count, 3);
    checkOutput("t4_ready_back", req_ready, 2'b01);
    checkOutput("t4_next_start", start, 1);
    req_valid = '0;

    // Completion stall and stray done pulses
    doReset();
    cpl_ready = 1'b0;
    done = 1'b1;
    tick();
    done = 1'b0;
    checkOutput("t5_stray_idle", idle, 1);
    checkOutput("t5_stray_cpl", cpl_valid, 0);
    applyStimulus(0, 8'd4, 8'd4, 8'd4, 4'd9);
    tick();
    req_valid = '0;
    tick();
    checkOutput("t5_start", start, 1);
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    checkOutput("t5_cpl_valid", cpl_valid, 1);
    applyStimulus(1, 8'd4, 8'd4, 8'd4, 4'd10);
    for (int c = 0; c < 10; c++) begin
      done = (c == 4);
      tick();
      req_valid = '0;
      checkOutput("t5_hold_valid", cpl_valid, 1);
      checkOutput("t5_hold_id", cpl_id, 9);
      checkOutput("t5_hold_no_start", start, 0);
    end
    done = 1'b0;
    checkOutput("t5_queued", queue_count, 1);
    cpl_ready = 1'b1;
    tick();
    checkOutput("t5_released", cpl_valid, 0);
    tick();
    checkOutput("t5_next_start", start, 1);
    checkOutput("t5_next_m", m_size, 4);

    // Reset while running with two queued jobs
    tick();
    applyStimulus(0, 8'd4, 8'd4, 8'd4, 4'd11);
    tick();
    req_id[0] = 4'd12;
    tick();
    req_valid = '0;
    checkOutput("t6_queued", queue_count, 2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_start", start, 0);
    checkOutput("t6_cpl_valid", cpl_valid, 0);
    checkOutput("t6_count", queue_count, 0);
    checkOutput("t6_idle", idle, 1);
    checkOutput("t6_m", m_size, 0);
    checkOutput("t6_cpl_id", cpl_id, 0);
    checkOutput("t6_ready", req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    any_cpl = 1'b0;
    any_start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      done = (c % 3 == 1);
      tick();
      any_cpl = any_cpl | cpl_valid;
      any_start = any_start | start;
    end
    done = 1'b0;
    checkOutput("t6_no_cpl", any_cpl, 0);
    checkOutput("t6_no_start", any_start, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
